tiny_fir_tap_loader: RTL and testbench

- Upstream configuration stage for the tiny FIR filter. It holds a writable shadow copy of the coefficient set.
- On a commit strobe it restarts the filter by pulsing its enable low, then streams all taps into the filter's tap programming port over a valid/ready handshake.
- It reports when the filter confirms the taps are loaded, so software can rewrite coefficients at any time without touching the datapath.

---
 rtl/tiny_fir_tap_loader.sv | 151 +++++++++++++++
 tb/tb_tiny_fir_tap_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_fir_tap_loader.sv
// tiny_fir_tap_loader: writable shadow coefficient store plus a load sequencer.
// On commit it holds the FIR disabled for a few cycles, then streams every tap
// over a valid/ready port and reports once the filter confirms the load.
module tiny_fir_tap_loader #(
  parameter int G_NUM_TAPS       = 16,
  parameter int G_TAP_WIDTH      = 16,
  parameter int G_DISABLE_CYCLES = 2,
  parameter int G_TIMEOUT        = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(G_NUM_TAPS)-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]        cfg_wr_data,
  input  logic                          cfg_commit,
  output logic                          busy,
  output logic                          loaded,
  output logic                          wr_dropped,
  output logic                          timeout_err,
  output logic                          fir_enable,
  output logic [G_TAP_WIDTH-1:0]        tap_dout,
  output logic                          tap_dout_valid,
  input  logic                          tap_dout_ready,
  input  logic                          tap_done
);

  localparam int AW = $clog2(G_NUM_TAPS);
  localparam int DW = $clog2(G_DISABLE_CYCLES + 1);
  localparam int TW = $clog2(G_TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_IDX = AW'(G_NUM_TAPS - 1);
  localparam logic [DW-1:0] DIS_LOAD = DW'(G_DISABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(G_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DISABLE   = 3'd1;
  localparam logic [2:0] S_STREAM    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_LIVE      = 3'd4;

  logic [2:0]             state;
  logic [AW-1:0]          tap_idx;
  logic [DW-1:0]          dis_cnt;
  logic [TW-1:0]          wait_cnt;
  logic [G_TAP_WIDTH-1:0] shadow [G_NUM_TAPS];
  logic                   wr_accept;

  // Busy covers the whole load sequence; shadow writes are only accepted outside it.
  assign busy      = (state == S_DISABLE) || (state == S_STREAM) || (state == S_WAIT_DONE);
  assign wr_accept = cfg_wr_en && !busy;

  // The tap bus only carries data while a coefficient is being offered.
  assign tap_dout = tap_dout_valid ? shadow[tap_idx] : '0;

  // Shadow coefficient array; a same-cycle commit sees the value written here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < G_NUM_TAPS; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_accept) begin
      shadow[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Load sequencer: disable window, tap streaming, done/timeout wait, live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      tap_idx        <= '0;
      dis_cnt        <= '0;
      wait_cnt       <= '0;
      fir_enable     <= 1'b0;
      tap_dout_valid <= 1'b0;
      loaded         <= 1'b0;
      wr_dropped     <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      if (cfg_wr_en) begin
        if (busy) begin
          wr_dropped <= 1'b1;
        end else begin
          loaded <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (cfg_commit) begin
            wr_dropped  <= 1'b0;
            timeout_err <= 1'b0;
            dis_cnt     <= DIS_LOAD;
            state       <= S_DISABLE;
          end
        end

        S_DISABLE: begin
          if (dis_cnt == '0) begin
            fir_enable     <= 1'b1;
            tap_idx        <= '0;
            tap_dout_valid <= 1'b1;
            state          <= S_STREAM;
          end else begin
            dis_cnt <= dis_cnt - 1'b1;
          end
        end

        S_STREAM: begin
          if (tap_dout_ready) begin
            if (tap_idx == LAST_IDX) begin
              tap_dout_valid <= 1'b0;
              wait_cnt       <= '0;
              state          <= S_WAIT_DONE;
            end else begin
              tap_idx <= tap_idx + 1'b1;
            end
          end
        end

        S_WAIT_DONE: begin
          if (tap_done) begin
            loaded <= 1'b1;
            state  <= S_LIVE;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            fir_enable  <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_LIVE: begin
          if (cfg_commit) begin
            loaded     <= 1'b0;
            fir_enable <= 1'b0;
            dis_cnt    <= DIS_LOAD;
            state      <= S_DISABLE;
          end
        end

        default: begin
          state          <= S_IDLE;
          fir_enable     <= 1'b0;
          tap_dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_fir_tap_loader.sv
// tb_tiny_fir_tap_loader: directed bench with a transaction-level model of the
// loader (shadow snapshot queue, disable countdown, wait counter) compared
// against the DUT on every falling edge, plus literal checks of key sequences.
module tb_tiny_fir_tap_loader;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int DIS = 2;
  localparam int TO  = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_wr_en = 1'b0;
  logic [1:0]   cfg_wr_addr = '0;
  logic [W-1:0] cfg_wr_data = '0;
  logic         cfg_commit = 1'b0;
  logic         tap_dout_ready = 1'b0;
  logic         tap_done = 1'b0;
  logic         busy, loaded, wr_dropped, timeout_err, fir_enable, tap_dout_valid;
  logic [W-1:0] tap_dout;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;
  logic [W-1:0] hs_log[$];

  // Model state: what software wrote, what is queued for the filter, and flags.
  bit [W-1:0] m_shadow[N];
  bit [W-1:0] m_pending[$];
  int m_off_left = 0;
  bit m_waiting = 1'b0;
  int m_wait_cnt = 0;
  bit m_live = 1'b0;
  bit m_loaded = 1'b0;
  bit m_dropped = 1'b0;
  bit m_timeout = 1'b0;
  bit m_en = 1'b0;

  tiny_fir_tap_loader #(
    .G_NUM_TAPS(N), .G_TAP_WIDTH(W), .G_DISABLE_CYCLES(DIS), .G_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_commit(cfg_commit), .busy(busy), .loaded(loaded),
    .wr_dropped(wr_dropped), .timeout_err(timeout_err), .fir_enable(fir_enable),
    .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid), .tap_dout_ready(tap_dout_ready),
    .tap_done(tap_done)
  );

  // Free-running clock.
  initial forever #5 clk = ~clk;

  function automatic bit m_busy();
    return (m_off_left > 0) || (m_pending.size() > 0) || m_waiting;
  endfunction

  function automatic bit m_valid();
    return (m_off_left == 0) && (m_pending.size() > 0);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a load is a snapshot of the shadow set delivered tap by tap.
  always @(posedge clk or negedge reset) begin : model_step
    bit wb;
    if (!reset) begin
      for (int i = 0; i < N; i++) m_shadow[i] = '0;
      m_pending.delete();
      m_off_left = 0; m_waiting = 0; m_wait_cnt = 0; m_live = 0;
      m_loaded = 0; m_dropped = 0; m_timeout = 0; m_en = 0;
    end else begin
      wb = m_busy();
      if (cfg_wr_en) begin
        if (wb) m_dropped = 1'b1;
        else begin
          m_shadow[cfg_wr_addr] = cfg_wr_data;
          m_loaded = 1'b0;
        end
      end
      if (!wb && cfg_commit) begin
        if (!m_live) begin
          m_dropped = 1'b0;
          m_timeout = 1'b0;
        end
        m_live = 0; m_loaded = 0; m_en = 0;
        m_off_left = DIS;
        m_pending.delete();
        for (int i = 0; i < N; i++) m_pending.push_back(m_shadow[i]);
      end else if (m_off_left > 0) begin
        m_off_left--;
        if (m_off_left == 0) m_en = 1'b1;
      end else if (m_pending.size() > 0) begin
        if (tap_dout_ready) begin
          void'(m_pending.pop_front());
          if (m_pending.size() == 0) begin
            m_waiting = 1'b1;
            m_wait_cnt = 0;
          end
        end
      end else if (m_waiting) begin
        if (tap_done) begin
          m_waiting = 0; m_live = 1; m_loaded = 1;
        end else begin
          m_wait_cnt++;
          if (m_wait_cnt == TO) begin
            m_waiting = 0; m_timeout = 1; m_en = 0;
          end
        end
      end
    end
  end

  // Record every accepted tap, in order.
  always @(posedge clk) begin
    if (reset && tap_dout_valid && tap_dout_ready) hs_log.push_back(tap_dout);
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check_output("busy", 32'(busy), 32'(m_busy()));
      check_output("loaded", 32'(loaded), 32'(m_loaded));
      check_output("wr_dropped", 32'(wr_dropped), 32'(m_dropped));
      check_output("timeout_err", 32'(timeout_err), 32'(m_timeout));
      check_output("fir_enable", 32'(fir_enable), 32'(m_en));
      check_output("tap_valid", 32'(tap_dout_valid), 32'(m_valid()));
      check_output("tap_dout", 32'(tap_dout), m_valid() ? 32'(m_pending[0]) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] addr, input logic [W-1:0] data);
    cfg_wr_en = 1'b1; cfg_wr_addr = addr; cfg_wr_data = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit_and_count();
    int n;
    n = 0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    while (!fir_enable && n < 20) begin
      n++;
      tick();
    end
    check_output("en_low_cycles", 32'(n), 32'(DIS));
  endtask

  task automatic stream(input int n_taps, input bit toggle, input bit wr_mid);
    int cyc;
    int start;
    bit wrote;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc = 0; wrote = 0; start = hs_log.size();
    while (hs_log.size() - start < n_taps && cyc < 60) begin
      tap_dout_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (wr_mid && !wrote && hs_log.size() - start == 1) begin
        cfg_wr_en = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = 16'h1234; wrote = 1'b1;
      end else begin
        cfg_wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    tap_dout_ready = 1'b0;
    cfg_wr_en = 1'b0;
    check_output("stream_count", 32'(hs_log.size() - start), 32'(n_taps));
  endtask

  task automatic finish_load();
    tap_done = 1'b1;
    tick();
    tap_done = 1'b0;
    check_output("done_loaded", 32'(loaded), 32'd1);
    check_output("done_busy", 32'(busy), 32'd0);
    check_output("done_enable", 32'(fir_enable), 32'd1);
  endtask

  task automatic check_log(input int start, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
    logic [W-1:0] e[4];
    e = '{e0, e1, e2, e3};
    check_output("log_size", 32'(hs_log.size() - start), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (start + i < hs_log.size()) check_output($sformatf("log_tap%0d", i), 32'(hs_log[start + i]), 32'(e[i]));
    end
  endtask

  initial begin
    int st;
    int n;
    repeat (3) tick();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_enable", 32'(fir_enable), 32'd0);
    check_output("rst_valid", 32'(tap_dout_valid), 32'd0);
    check_output("rst_dout", 32'(tap_dout), 32'd0);
    check_output("rst_loaded", 32'(loaded), 32'd0);
    reset = 1'b1;
    cmp_on = 1'b1;
    tick();

    $display("[TB] basic load, ready held high");
    apply_stimulus(2'd0, 16'h4000);
    apply_stimulus(2'd1, 16'h2000);
    apply_stimulus(2'd2, 16'hE000);
    apply_stimulus(2'd3, 16'h0001);
    st = hs_log.size();
    commit_and_count();
    stream(4, 1'b0, 1'b0);
    check_log(st, 16'h4000, 16'h2000, 16'hE000, 16'h0001);
    finish_load();

    $display("[TB] reload with ready toggling");
    st = hs_log.size();
    commit_and_count();
    stream(4, 1'b1, 1'b0);
    repeat (3) tick();
    check_log(st, 16'h4000, 16'h2000, 16'hE000, 16'h0001);
    finish_load();

    $display("[TB] rewrite tap 2 while live");
    apply_stimulus(2'd2, 16'h7FFF);
    check_output("write_clears_loaded", 32'(loaded), 32'd0);
    st = hs_log.size();
    commit_and_count();
    stream(4, 1'b0, 1'b0);
    check_log(st, 16'h4000, 16'h2000, 16'h7FFF, 16'h0001);
    finish_load();

    $display("[TB] write during stream is dropped");
    st = hs_log.size();
    commit_and_count();
    stream(4, 1'b1, 1'b1);
    check_output("wr_dropped_set", 32'(wr_dropped), 32'd1);
    check_log(st, 16'h4000, 16'h2000, 16'h7FFF, 16'h0001);
    finish_load();
    st = hs_log.size();
    commit_and_count();
    stream(4, 1'b0, 1'b0);
    check_log(st, 16'h4000, 16'h2000, 16'h7FFF, 16'h0001);
    finish_load();

    $display("[TB] missing tap_done times out");
    commit_and_count();
    stream(4, 1'b0, 1'b0);
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    check_output("timeout_cycles", 32'(n), 32'(TO));
    check_output("timeout_enable", 32'(fir_enable), 32'd0);
    check_output("timeout_busy", 32'(busy), 32'd0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check_output("commit_clears_timeout", 32'(timeout_err), 32'd0);
    check_output("commit_clears_dropped", 32'(wr_dropped), 32'd0);
    check_output("commit_busy", 32'(busy), 32'd1);

    $display("[TB] reset in the middle of streaming");
    stream(2, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_output("async_valid", 32'(tap_dout_valid), 32'd0);
    check_output("async_enable", 32'(fir_enable), 32'd0);
    check_output("async_busy", 32'(busy), 32'd0);
    check_output("async_dout", 32'(tap_dout), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    st = hs_log.size();
    commit_and_count();
    stream(4, 1'b0, 1'b0);
    check_log(st, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    finish_load();

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
